// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the data-memory responder.
//   state_e         : responder FSM states (IDLE / BUSY / DONE)
//   SZ_*            : access-size encodings carried on sizeM
//   byte_en()       : byte-lane enables from access size and addr[1:0]
//   is_misaligned() : alignment check for half/word accesses
//   steer_wdata()   : replicates right-justified store data onto every lane
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Reserved size 2'b11 falls into the default arm and behaves as a word.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Data is copied onto every lane it could land in; byte_en picks the lane.
  function automatic logic [31:0] steer_wdata(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{data[7:0]}};
      SZ_HALF: w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if -- M-stage data-port bundle between CPU and responder.
//   memreadM / memwriteM : load / store request
//   addrM                : byte address
//   writedataM           : right-justified store data
//   sizeM                : access size (mem_pkg SZ_*)
//   readdataM            : aligned raw word returned for loads
//   stallM               : CPU must hold the M stage while high
//   misalignM            : one-cycle misaligned-access pulse
// Modports: master = CPU side, slave = memory side.
interface dmem_responder_if;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] addrM;
  logic [31:0] writedataM;
  logic [1:0]  sizeM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        misalignM;

  modport master (
    output memreadM, memwriteM, addrM, writedataM, sizeM,
    input  readdataM, stallM, misalignM
  );

  modport slave (
    input  memreadM, memwriteM, addrM, writedataM, sizeM,
    output readdataM, stallM, misalignM
  );
endinterface

// File: rtl/dmem_ram_sp.sv
// dmem_ram_sp -- single-port synchronous RAM, 32-bit words.
//   clk   : clock
//   addr  : word address
//   we/be : write enable and per-byte lane enables
//   wdata : write data (lane-steered by the caller)
//   re    : read enable; rdata is registered and holds when re is low
// Contents are intentionally not reset.
module dmem_ram_sp #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1 << ADDR_W)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register only updates on a read so the last load value persists.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder -- memory-side responder for the pipelined core's M stage.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : dmem_responder_if.slave (request in, readdata/stall/misalign out)
// A request is latched in IDLE, waits WAIT_CYCLES extra cycles in BUSY, the
// RAM access happens on the edge leaving BUSY, and results appear in DONE.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  dmem_responder_if.slave    bus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                store_q, store_d;
  logic                rd_sel_q, rd_sel_d;
  logic                misalign_q, misalign_d;

  logic                req_s;
  logic                access_s;
  logic                mis_s;
  logic                ram_we_s;
  logic                ram_re_s;
  logic [3:0]          ram_be_s;
  logic [31:0]         ram_wdata_s;
  logic [31:0]         ram_rdata_s;
  logic                unused_addr_s;

  assign req_s = bus.memreadM | bus.memwriteM;
  // Upper address bits do not take part: addresses wrap modulo the RAM size.
  assign unused_addr_s = ^bus.addrM[31:ADDR_W+2];

  // Next-state, request latching and RAM access decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    store_d    = store_q;
    access_s   = 1'b0;
    mis_s      = is_misaligned(size_q, addr_q[1:0]);
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d = ST_BUSY;
          cnt_d   = WAIT_INIT;
          addr_d  = bus.addrM[ADDR_W+1:0];
          wdata_d = bus.writedataM;
          size_d  = bus.sizeM;
          // Both request lines high is treated as a store.
          store_d = bus.memwriteM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_DONE;
          access_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // Request inputs are still presented here but belong to the access
        // that just finished, so they are ignored.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ram_we_s    = access_s & store_q & ~mis_s;
    ram_re_s    = access_s & ~store_q & ~mis_s;
    ram_be_s    = byte_en(size_q, addr_q[1:0]);
    ram_wdata_s = steer_wdata(size_q, wdata_q);

    // rd_sel marks whether the RAM read register holds the last completed
    // result; stores and misaligned accesses return zero instead.
    if (access_s) begin
      rd_sel_d = ~store_q & ~mis_s;
    end else begin
      rd_sel_d = rd_sel_q;
    end
    misalign_d = access_s & mis_s;
  end

  // State and latched request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      size_q     <= SZ_BYTE;
      store_q    <= 1'b0;
      rd_sel_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      store_q    <= store_d;
      rd_sel_q   <= rd_sel_d;
      misalign_q <= misalign_d;
    end
  end

  dmem_ram_sp #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .addr  (addr_q[ADDR_W+1:2]),
    .we    (ram_we_s),
    .be    (ram_be_s),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .rdata (ram_rdata_s)
  );

  // Stall is combinational in IDLE so the CPU holds in the request cycle.
  assign bus.stallM    = ((state_q == ST_IDLE) && req_s) || (state_q == ST_BUSY);
  assign bus.readdataM = rd_sel_q ? ram_rdata_s : 32'h0000_0000;
  assign bus.misalignM = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- self-checking bench for dmem_responder.
// Two instances: dut1 with WAIT_CYCLES=1, dut0 with WAIT_CYCLES=0.
// Expected values come from a byte-addressed little-endian memory model.
module tb_dmem_responder;

  logic clk;
  logic rst1;
  logic rst0;
  int   checks;
  int   failures;

  logic [7:0] mb [0:1][0:4095];

  dmem_responder_if if1 ();
  dmem_responder_if if0 ();

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_stall(input bit f);
    return f ? if0.stallM : if1.stallM;
  endfunction

  function automatic logic [31:0] get_rdata(input bit f);
    return f ? if0.readdataM : if1.readdataM;
  endfunction

  function automatic logic get_mis(input bit f);
    return f ? if0.misalignM : if1.misalignM;
  endfunction

  task automatic drive(input bit f, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    if (f) begin
      if0.memreadM = rd; if0.memwriteM = wr; if0.addrM = a; if0.writedataM = d; if0.sizeM = sz;
    end else begin
      if1.memreadM = rd; if1.memwriteM = wr; if1.addrM = a; if1.writedataM = d; if1.sizeM = sz;
    end
  endtask

  task automatic idle(input bit f);
    drive(f, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
  endtask

  // Reference: size 3 acts as word; half/word must be naturally aligned.
  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return (a % 4) != 0;
  endfunction

  // Issue one request at posedge+1, follow it to DONE, check it, and return
  // at posedge+1 of the following cycle with the request still driven.
  task automatic run_op(input bit f, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                        input string tag);
    int cyc;
    int b;
    int w;
    logic mis;
    logic [31:0] exp_rd;
    drive(f, rd, wr, a, d, sz);
    #1;
    cyc = 0;
    while (get_stall(f) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), f ? 32'd2 : 32'd3);
    mis = model_mis(sz, a);
    b = int'(a % 4096);
    w = b - (b % 4);
    if (wr || mis) exp_rd = 32'h0;
    else exp_rd = {mb[f][w+3], mb[f][w+2], mb[f][w+1], mb[f][w]};
    chk({tag, "_rdata"}, get_rdata(f), exp_rd);
    chk({tag, "_mis"}, 32'(get_mis(f)), 32'(mis));
    if (wr && !mis) begin
      if (sz == 2'b00) begin
        mb[f][b] = d[7:0];
      end else if (sz == 2'b01) begin
        mb[f][b] = d[7:0]; mb[f][b+1] = d[15:8];
      end else begin
        for (int k = 0; k < 4; k++) mb[f][w+k] = d[8*k +: 8];
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_mispulse"}, 32'(get_mis(f)), 32'h0);
  endtask

  task automatic random_ops(input bit f, input int n);
    logic [31:0] r;
    logic [31:0] a;
    int op;
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      a = {r[31:12], 10'h200 + 10'(i), 2'b00};
      run_op(f, 1'b0, 1'b1, a, $urandom(), 2'b10, "rinit");
    end
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      a = {r[31:12], 10'h200 + 10'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 2);
      run_op(f, op != 1, op != 0, a, $urandom(), 2'($urandom_range(0, 3)), "rand");
    end
    idle(f);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst1 = 1'b1;
    rst0 = 1'b1;
    idle(1'b0);
    idle(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall1", 32'(if1.stallM), 32'h0);
    chk("rst_rdata1", if1.readdataM, 32'h0);
    chk("rst_mis1", 32'(if1.misalignM), 32'h0);
    chk("rst_stall0", 32'(if0.stallM), 32'h0);
    chk("rst_rdata0", if0.readdataM, 32'h0);
    rst1 = 1'b0;
    rst0 = 1'b0;
    @(posedge clk);
    #1;

    // Word store then load, WAIT_CYCLES=1.
    run_op(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, "sw10");
    run_op(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 2'b10, "lw10");
    idle(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rdata_hold", if1.readdataM, 32'hDEADBEEF);

    // Byte and half lane steering.
    run_op(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 2'b10, "sw20");
    run_op(1'b0, 1'b0, 1'b1, 32'h21, 32'hFFFF_FFAB, 2'b00, "sb21");
    run_op(1'b0, 1'b0, 1'b1, 32'h22, 32'hFFFF_1234, 2'b01, "sh22");
    run_op(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2'b10, "lw20");
    chk("lw20_const", if1.readdataM, 32'h1234AB00);

    // Misaligned accesses.
    run_op(1'b0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 2'b10, "sw30");
    run_op(1'b0, 1'b0, 1'b1, 32'h31, 32'h5678, 2'b01, "sh31mis");
    run_op(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 2'b10, "lw30");
    chk("lw30_const", if1.readdataM, 32'hCAFEF00D);
    run_op(1'b0, 1'b1, 1'b0, 32'h32, 32'h0, 2'b10, "lw32mis");

    // Reset while BUSY drops the pending store.
    run_op(1'b0, 1'b0, 1'b1, 32'h40, 32'h11111111, 2'b10, "sw40");
    run_op(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, "lw40a");
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h55, 2'b10);
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    #1;
    idle(1'b0);
    #1;
    chk("busyrst_stall", 32'(if1.stallM), 32'h0);
    chk("busyrst_rdata", if1.readdataM, 32'h0);
    chk("busyrst_mis", 32'(if1.misalignM), 32'h0);
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    run_op(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 2'b10, "lw40b");
    chk("lw40b_const", if1.readdataM, 32'h11111111);

    // Address wrap and simultaneous read+write.
    run_op(1'b0, 1'b0, 1'b1, 32'h1000, 32'h1, 2'b10, "sw1000");
    run_op(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b10, "lw0");
    chk("wrap_const", if1.readdataM, 32'h1);
    run_op(1'b0, 1'b1, 1'b1, 32'h50, 32'h77, 2'b10, "both50");
    run_op(1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 2'b10, "lw50");
    chk("both_const", if1.readdataM, 32'h77);

    random_ops(1'b0, 80);

    // WAIT_CYCLES=0 instance.
    run_op(1'b1, 1'b0, 1'b1, 32'h60, 32'h9, 2'b10, "f_sw60");
    run_op(1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 2'b10, "f_lw60");
    chk("held_accept", 32'(if0.stallM), 32'h1);
    run_op(1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 2'b10, "f_lw60b");
    chk("f_lw60_const", if0.readdataM, 32'h9);
    idle(1'b1);
    random_ops(1'b1, 40);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
